// File: rtl/zc_pkg.sv
// Shared encodings for the zero-crossing detector: region state, sample class
// and the dir_mode bit positions.
package zc_pkg;

    // Region the signal was last seen in (carried across beats).
    localparam logic [1:0] REG_UNK = 2'b00;
    localparam logic [1:0] REG_POS = 2'b01;
    localparam logic [1:0] REG_NEG = 2'b10;

    // Per-sample hysteresis class. POS/NEG deliberately share the region codes
    // so a class can be written straight into the region state.
    typedef enum logic [1:0] {
        CLS_DEAD = 2'b00,
        CLS_POS  = 2'b01,
        CLS_NEG  = 2'b10
    } zc_class_e;

    // Bit positions inside dir_mode.
    localparam int DIR_RISE = 0;
    localparam int DIR_FALL = 1;

endpackage

// File: rtl/zc_classify.sv
// Combinational hysteresis classifier for one sample: POS, NEG or DEAD band.
module zc_classify
    import zc_pkg::*;
#(
    parameter int DATA_WIDTH = 20
) (
    input  logic [DATA_WIDTH-1:0] i_x,
    input  logic [DATA_WIDTH-2:0] i_thresh,
    output logic [1:0]            o_class
);

    // One extra bit so that -thresh is always representable.
    logic signed [DATA_WIDTH:0] w_x;
    logic signed [DATA_WIDTH:0] w_th;
    logic signed [DATA_WIDTH:0] w_nth;

    assign w_x   = {i_x[DATA_WIDTH-1], i_x};
    assign w_th  = {2'b00, i_thresh};
    assign w_nth = -w_th;

    // Zero is treated as positive; magnitudes inside the band are DEAD.
    always_comb begin
        o_class = CLS_DEAD;
        if (!w_x[DATA_WIDTH] && (w_x >= w_th)) begin
            o_class = CLS_POS;
        end else if (w_x[DATA_WIDTH] && (w_x <= w_nth)) begin
            o_class = CLS_NEG;
        end
    end

endmodule

// File: rtl/zero_cross_detect_v3.sv
// Zero-crossing detector for a 16:1 deserialised difference stream.
// Three-stage pipeline: classify+register, serial region/holdoff scan,
// output encode (first index, popcount).
module zero_cross_detect_v3
    import zc_pkg::*;
#(
    parameter  int NUM_CHANNELS  = 16,
    parameter  int DATA_WIDTH    = 20,
    parameter  int HOLDOFF_WIDTH = 8,
    localparam int IDX_W         = $clog2(NUM_CHANNELS),
    localparam int CNT_W         = $clog2(NUM_CHANNELS + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid_in,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] diff_in,
    input  logic [DATA_WIDTH-2:0]            thresh,
    input  logic [1:0]                       dir_mode,
    input  logic [HOLDOFF_WIDTH-1:0]         holdoff,
    input  logic                             clear,
    output logic [NUM_CHANNELS-1:0]          zero_mask,
    output logic [NUM_CHANNELS-1:0]          zero_direction,
    output logic                             any_cross,
    output logic [IDX_W-1:0]                 first_idx,
    output logic [CNT_W-1:0]                 cross_cnt,
    output logic                             valid_out
);

    logic [2*NUM_CHANNELS-1:0] w_class;

    logic [2*NUM_CHANNELS-1:0] r1_class;
    logic                      r1_valid;
    logic                      r1_clear;
    logic [1:0]                r1_dir_mode;
    logic [HOLDOFF_WIDTH-1:0]  r1_holdoff;

    logic [1:0]                r_region;
    logic [HOLDOFF_WIDTH-1:0]  r_hcnt;
    logic [1:0]                w_rgn;
    logic [HOLDOFF_WIDTH-1:0]  w_hc;
    logic [1:0]                w_cls;
    logic                      w_rise;
    logic                      w_en;
    logic                      w_acc;
    logic [NUM_CHANNELS-1:0]   w_mask;
    logic [NUM_CHANNELS-1:0]   w_dir;

    logic                      r2_valid;
    logic [NUM_CHANNELS-1:0]   r2_mask;
    logic [NUM_CHANNELS-1:0]   r2_dir;
    logic [IDX_W-1:0]          w_first;
    logic [CNT_W-1:0]          w_pop;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_cls
        zc_classify #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_cls (
            .i_x      (diff_in[g*DATA_WIDTH +: DATA_WIDTH]),
            .i_thresh (thresh),
            .o_class  (w_class[2*g +: 2])
        );
    end

    // S1: capture classes and the per-beat configuration alongside valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_class    <= '0;
            r1_valid    <= 1'b0;
            r1_clear    <= 1'b0;
            r1_dir_mode <= '0;
            r1_holdoff  <= '0;
        end else begin
            r1_class    <= w_class;
            r1_valid    <= valid_in;
            r1_clear    <= clear;
            r1_dir_mode <= dir_mode;
            r1_holdoff  <= holdoff;
        end
    end

    // S2 next-state: walk ch0..chN-1 carrying region and holdoff count.
    always_comb begin
        w_rgn  = r1_clear ? REG_UNK : r_region;
        w_hc   = r1_clear ? '0 : r_hcnt;
        w_mask = '0;
        w_dir  = '0;
        w_cls  = CLS_DEAD;
        w_rise = 1'b0;
        w_en   = 1'b0;
        w_acc  = 1'b0;
        if (r1_valid) begin
            for (int g = 0; g < NUM_CHANNELS; g++) begin
                w_cls  = r1_class[2*g +: 2];
                w_rise = (w_cls == CLS_POS);
                w_en   = w_rise ? r1_dir_mode[DIR_RISE] : r1_dir_mode[DIR_FALL];
                w_acc  = 1'b0;
                if (w_cls != CLS_DEAD) begin
                    if (w_rgn == REG_UNK) begin
                        w_rgn = w_cls;
                    end else if (w_cls != w_rgn) begin
                        if (w_en && (w_hc == '0)) begin
                            w_acc     = 1'b1;
                            w_mask[g] = 1'b1;
                            w_dir[g]  = w_rise;
                            w_hc      = r1_holdoff;
                        end
                        w_rgn = w_cls;
                    end
                end
                if (!w_acc && (w_hc != '0)) begin
                    w_hc = w_hc - HOLDOFF_WIDTH'(1);
                end
            end
        end
    end

    // S2 registers: region/holdoff state and the per-beat crossing result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_region <= REG_UNK;
            r_hcnt   <= '0;
            r2_valid <= 1'b0;
            r2_mask  <= '0;
            r2_dir   <= '0;
        end else begin
            r_region <= w_rgn;
            r_hcnt   <= w_hc;
            r2_valid <= r1_valid;
            r2_mask  <= w_mask;
            r2_dir   <= w_dir;
        end
    end

    // S3 encode: lowest set mask bit and number of crossings.
    always_comb begin
        w_first = '0;
        w_pop   = '0;
        for (int g = NUM_CHANNELS - 1; g >= 0; g--) begin
            if (r2_mask[g]) begin
                w_first = IDX_W'(g);
            end
        end
        for (int g = 0; g < NUM_CHANNELS; g++) begin
            w_pop = w_pop + CNT_W'(r2_mask[g]);
        end
    end

    // S3 registers: outputs; mask is already zero on invalid beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_mask      <= '0;
            zero_direction <= '0;
            any_cross      <= 1'b0;
            first_idx      <= '0;
            cross_cnt      <= '0;
            valid_out      <= 1'b0;
        end else begin
            zero_mask      <= r2_mask;
            zero_direction <= r2_dir & r2_mask;
            any_cross      <= |r2_mask;
            first_idx      <= w_first;
            cross_cnt      <= w_pop;
            valid_out      <= r2_valid;
        end
    end

endmodule

// File: tb/tb_zero_cross_detect_v3.sv
// Self-checking bench for zero_cross_detect_v3: per-sample reference model
// feeding a scoreboard, a negedge monitor, and scenario tasks.
module tb_zero_cross_detect_v3;

    localparam int N  = 16;
    localparam int W  = 20;
    localparam int TW = W - 1;
    localparam int HW = 8;
    localparam int IW = 4;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid_in = 1'b0;
    logic [N*W-1:0]    diff_in = '0;
    logic [TW-1:0]     thresh = '0;
    logic [1:0]        dir_mode = '0;
    logic [HW-1:0]     holdoff = '0;
    logic              clear = 1'b0;
    logic [N-1:0]      zero_mask;
    logic [N-1:0]      zero_direction;
    logic              any_cross;
    logic [IW-1:0]     first_idx;
    logic [CW-1:0]     cross_cnt;
    logic              valid_out;

    zero_cross_detect_v3 #(
        .NUM_CHANNELS  (N),
        .DATA_WIDTH    (W),
        .HOLDOFF_WIDTH (HW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .diff_in        (diff_in),
        .thresh         (thresh),
        .dir_mode       (dir_mode),
        .holdoff        (holdoff),
        .clear          (clear),
        .zero_mask      (zero_mask),
        .zero_direction (zero_direction),
        .any_cross      (any_cross),
        .first_idx      (first_idx),
        .cross_cnt      (cross_cnt),
        .valid_out      (valid_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] mask;
        logic [N-1:0] dir;
        int           exp_cyc;
    } exp_t;

    exp_t         sb[$];
    logic [N-1:0] obs_mask[$];
    logic [N-1:0] obs_dir[$];
    int           obs_first[$];
    int           obs_cnt[$];

    int beat[N];
    int m_region = 0;
    int m_cnt = 0;

    function automatic int cls_of(input int x, input int t);
        if (x >= 0 && x >= t) return 1;
        if (x < 0 && x <= -t) return 2;
        return 0;
    endfunction

    // Model the beat sample by sample, push the expectation, drive one cycle.
    task automatic drive_beat(input int th, input int dm, input int ho, input bit clr);
        exp_t e;
        int   c;
        bit   acc;
        bit   rise;
        if (clr) begin
            m_region = 0;
            m_cnt = 0;
        end
        e.mask = '0;
        e.dir = '0;
        for (int g = 0; g < N; g++) begin
            c = cls_of(beat[g], th);
            acc = 1'b0;
            if (c != 0) begin
                if (m_region == 0) begin
                    m_region = c;
                end else if (c != m_region) begin
                    rise = (c == 1);
                    if ((((dm >> (rise ? 0 : 1)) & 1) == 1) && m_cnt == 0) begin
                        acc = 1'b1;
                        e.mask[g] = 1'b1;
                        e.dir[g] = rise;
                        m_cnt = ho;
                    end
                    m_region = c;
                end
            end
            if (!acc && m_cnt > 0) m_cnt--;
            diff_in[g*W +: W] = W'(beat[g]);
        end
        thresh = TW'(th);
        dir_mode = 2'(dm);
        holdoff = HW'(ho);
        clear = clr;
        valid_in = 1'b1;
        e.exp_cyc = cyc + 3;
        sb.push_back(e);
        @(negedge clk);
        valid_in = 1'b0;
        clear = 1'b0;
    endtask

    task automatic fill(input int v);
        for (int g = 0; g < N; g++) beat[g] = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() > 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (sb.size() > 0) begin
            $display("FAIL drain_timeout: %0d beats still pending, required 0", sb.size());
            errors++;
            sb.delete();
        end
    endtask

    task automatic clear_obs();
        obs_mask.delete();
        obs_dir.delete();
        obs_first.delete();
        obs_cnt.delete();
    endtask

    // Monitor: compare every output beat with the scoreboard, idle outputs with 0.
    exp_t me;
    int   mf;
    int   mc;
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: valid_out=1 at cycle %0d, required no output", cyc);
            end else begin
                me = sb.pop_front();
                mf = 0;
                mc = 0;
                for (int g = N - 1; g >= 0; g--) if (me.mask[g]) mf = g;
                for (int g = 0; g < N; g++) if (me.mask[g]) mc++;
                if (cyc !== me.exp_cyc) begin
                    errors++;
                    $display("FAIL latency: output at cycle %0d, required %0d", cyc, me.exp_cyc);
                end
                if (zero_mask !== me.mask) begin
                    errors++;
                    $display("FAIL mask: got %h, required %h", zero_mask, me.mask);
                end
                if (zero_direction !== me.dir) begin
                    errors++;
                    $display("FAIL direction: got %h, required %h", zero_direction, me.dir);
                end
                if (any_cross !== (me.mask != 0)) begin
                    errors++;
                    $display("FAIL any_cross: got %b, required %b", any_cross, me.mask != 0);
                end
                if (first_idx !== IW'(mf)) begin
                    errors++;
                    $display("FAIL first_idx: got %0d, required %0d", first_idx, mf);
                end
                if (cross_cnt !== CW'(mc)) begin
                    errors++;
                    $display("FAIL cross_cnt: got %0d, required %0d", cross_cnt, mc);
                end
                obs_mask.push_back(zero_mask);
                obs_dir.push_back(zero_direction);
                obs_first.push_back(int'(first_idx));
                obs_cnt.push_back(int'(cross_cnt));
            end
        end else begin
            checks++;
            if (valid_out !== 1'b0 || zero_mask !== '0 || zero_direction !== '0 ||
                any_cross !== 1'b0 || first_idx !== '0 || cross_cnt !== '0) begin
                errors++;
                $display("FAIL idle_outputs: valid=%b mask=%h dir=%h any=%b first=%0d cnt=%0d, required all 0",
                         valid_out, zero_mask, zero_direction, any_cross, first_idx, cross_cnt);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++;
        if (valid_out !== 1'b0 || zero_mask !== '0 || cross_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b mask=%h cnt=%0d, required 0/0/0", valid_out, zero_mask, cross_cnt);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        clear_obs();
        fill(-1);
        drive_beat(0, 3, 0, 1'b1);
        for (int g = 0; g < N; g++) beat[g] = g - 8;
        drive_beat(0, 3, 0, 1'b0);
        wait_drain();
        checks++;
        if (obs_mask.size() != 2) begin
            errors++;
            $display("FAIL basic_count: got %0d beats, required 2", obs_mask.size());
        end else begin
            if (obs_mask[0] !== 16'h0000 || obs_mask[1] !== 16'h0100 || obs_dir[1] !== 16'h0100 ||
                obs_first[1] != 8 || obs_cnt[1] != 1) begin
                errors++;
                $display("FAIL basic_values: mask0=%h mask1=%h dir1=%h first=%0d cnt=%0d, required 0000/0100/0100/8/1",
                         obs_mask[0], obs_mask[1], obs_dir[1], obs_first[1], obs_cnt[1]);
            end
        end
    endtask

    task automatic test_hysteresis();
        clear_obs();
        for (int b = 0; b < 3; b++) begin
            for (int g = 0; g < N; g++) beat[g] = (g % 2 == 0) ? 3 : -3;
            drive_beat(16, 3, 0, b == 0);
        end
        fill(0);
        beat[0] = -20;
        beat[5] = 20;
        drive_beat(16, 3, 0, 1'b0);
        wait_drain();
        checks++;
        if (obs_mask.size() != 4) begin
            errors++;
            $display("FAIL hyst_count: got %0d beats, required 4", obs_mask.size());
        end else if ((obs_mask[0] | obs_mask[1] | obs_mask[2]) !== 16'h0000 ||
                     obs_mask[3] !== 16'h0020 || obs_dir[3] !== 16'h0020) begin
            errors++;
            $display("FAIL hyst_values: dead-band or=%h mask3=%h dir3=%h, required 0000/0020/0020",
                     obs_mask[0] | obs_mask[1] | obs_mask[2], obs_mask[3], obs_dir[3]);
        end
    endtask

    task automatic test_holdoff();
        clear_obs();
        for (int g = 0; g < N; g++) beat[g] = (g >= 14) ? 10 : -10;
        drive_beat(0, 3, 20, 1'b1);
        for (int g = 0; g < N; g++) beat[g] = (g < 2) ? 10 : -10;
        drive_beat(0, 3, 20, 1'b0);
        for (int g = 0; g < N; g++) beat[g] = (g == 2) ? 10 : -10;
        drive_beat(0, 3, 20, 1'b0);
        wait_drain();
        checks++;
        if (obs_mask.size() != 3) begin
            errors++;
            $display("FAIL holdoff_count: got %0d beats, required 3", obs_mask.size());
        end else if (obs_mask[0] !== 16'h4000 || obs_dir[0] !== 16'h4000 || obs_mask[1] !== 16'h0000 ||
                     obs_mask[2] !== 16'h0008 || obs_dir[2] !== 16'h0000) begin
            errors++;
            $display("FAIL holdoff_values: %h/%h %h %h/%h, required 4000/4000 0000 0008/0000",
                     obs_mask[0], obs_dir[0], obs_mask[1], obs_mask[2], obs_dir[2]);
        end
    endtask

    task automatic test_direction();
        clear_obs();
        for (int g = 0; g < N; g++) beat[g] = (g % 8 < 4) ? 100 : -100;
        drive_beat(0, 1, 0, 1'b1);
        drive_beat(0, 1, 0, 1'b0);
        drive_beat(0, 0, 0, 1'b0);
        drive_beat(0, 0, 0, 1'b0);
        drive_beat(0, 3, 0, 1'b0);
        wait_drain();
        checks++;
        if (obs_mask.size() != 5) begin
            errors++;
            $display("FAIL dir_count: got %0d beats, required 5", obs_mask.size());
        end else if (obs_mask[0] !== 16'h0100 || obs_mask[1] !== 16'h0101 || obs_dir[1] !== 16'h0101 ||
                     obs_mask[2] !== 16'h0000 || obs_mask[3] !== 16'h0000 ||
                     obs_mask[4] !== 16'h1111 || obs_dir[4] !== 16'h0101) begin
            errors++;
            $display("FAIL dir_values: %h %h/%h %h %h %h/%h, required 0100 0101/0101 0000 0000 1111/0101",
                     obs_mask[0], obs_mask[1], obs_dir[1], obs_mask[2], obs_mask[3], obs_mask[4], obs_dir[4]);
        end
    endtask

    task automatic test_gap_clear();
        clear_obs();
        fill(-50);
        drive_beat(0, 3, 0, 1'b1);
        idle(5);
        fill(50);
        drive_beat(0, 3, 0, 1'b0);
        fill(-50);
        drive_beat(0, 3, 0, 1'b0);
        idle(5);
        fill(50);
        drive_beat(0, 3, 0, 1'b1);
        wait_drain();
        checks++;
        if (obs_mask.size() != 4) begin
            errors++;
            $display("FAIL gap_count: got %0d beats, required 4", obs_mask.size());
        end else if (obs_mask[1] !== 16'h0001 || obs_dir[1] !== 16'h0001 || obs_mask[3] !== 16'h0000) begin
            errors++;
            $display("FAIL gap_values: gap=%h/%h cleared=%h, required 0001/0001 0000",
                     obs_mask[1], obs_dir[1], obs_mask[3]);
        end
    endtask

    task automatic test_reset_mid();
        int vcount = 0;
        clear_obs();
        fill(-50);
        drive_beat(0, 3, 0, 1'b1);
        fill(50);
        drive_beat(0, 3, 0, 1'b0);
        fill(-50);
        drive_beat(0, 3, 0, 1'b0);
        fill(50);
        drive_beat(0, 3, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || zero_mask !== '0 || zero_direction !== '0 || cross_cnt !== '0) begin
            errors++;
            $display("FAIL reset_async: valid=%b mask=%h dir=%h cnt=%0d, required all 0",
                     valid_out, zero_mask, zero_direction, cross_cnt);
        end
        sb.delete();
        m_region = 0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (valid_out === 1'b1) vcount++;
        end
        checks++;
        if (vcount != 0) begin
            errors++;
            $display("FAIL reset_drop: %0d dropped beats emerged, required 0", vcount);
        end
        clear_obs();
        fill(50);
        drive_beat(0, 3, 0, 1'b0);
        fill(-50);
        drive_beat(0, 3, 0, 1'b0);
        wait_drain();
        checks++;
        if (obs_mask.size() != 2) begin
            errors++;
            $display("FAIL reset_after_count: got %0d beats, required 2", obs_mask.size());
        end else if (obs_mask[0] !== 16'h0000 || obs_mask[1] !== 16'h0001 || obs_dir[1] !== 16'h0000) begin
            errors++;
            $display("FAIL reset_after_values: %h %h/%h, required 0000 0001/0000",
                     obs_mask[0], obs_mask[1], obs_dir[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 24; b++) begin
            for (int g = 0; g < N; g++) beat[g] = int'($urandom_range(0, 160)) - 80;
            drive_beat(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 24)), (b == 0) || ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        wait_drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_hysteresis();
        test_holdoff();
        test_direction();
        test_gap_clear();
        test_reset_mid();
        test_back_to_back();
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
